rnd_arbiter: RTL and testbench

Round-robin arbiter that shares the single free-running 6-bit LFSR random source among several game-logic requesters. Each requester asks for a random number in the range 0..limit-1. The block grants requesters one at a time and draws fresh LFSR samples, using mask-and-reject range reduction with a bounded retry count. It sits between the LFSR instance and the game FSMs (spawn position, event selection, etc.), so that no two consumers ever receive the same sample.

---
 rtl/rnd_arbiter.sv | 127 ++++++++++++
 tb/tb_rnd_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rnd_arbiter.sv
// Round-robin arbiter handing out range-reduced LFSR samples to N_REQ requesters.
// One grant per IDLE/DRAW..DRAW/ACK pass; mask-and-reject with a bounded retry count.
module rnd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 6,
  parameter int MAX_TRY = 7,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       rnd_in,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] limit,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       value,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id
);

  localparam int TW = 4;

  typedef enum logic [1:0] {IDLE, DRAW, ACK} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, gid_n, pick;
  logic [W-1:0]    lim, lim_n, value_n;
  logic [TW-1:0]   try_q, try_n, try_inc;
  logic [W-1:0]    mask, m;
  logic [W:0]      lim_ext;
  logic            accept;

  // Fill every bit below the highest set bit: smallest 2^k-1 covering x.
  function automatic logic [W-1:0] smear(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         acc;
    acc = 1'b0;
    r   = '0;
    for (int b = W - 1; b >= 0; b--) begin
      acc  = acc | x[b];
      r[b] = acc;
    end
    return r;
  endfunction

  // First requester at or after p, wrapping; lowest offset wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W-1:0] g;
    int              idx;
    g = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) g = ID_W'(idx);
    end
    return g;
  endfunction

  // lim==0 encodes 2^W, so lim-1 wraps to all ones and the compare gets an extra bit.
  always_comb begin
    mask    = smear(lim - W'(1));
    m       = rnd_in & mask;
    lim_ext = (lim == '0) ? {1'b1, {W{1'b0}}} : {1'b0, lim};
    accept  = ({1'b0, m} < lim_ext);
    try_inc = try_q + TW'(1);
    pick    = rr_pick(req, ptr);
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gid_n   = grant_id;
    lim_n   = lim;
    try_n   = try_q;
    value_n = value;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gid_n   = pick;
          lim_n   = limit[pick*W +: W];
          try_n   = '0;
          state_n = DRAW;
        end
      end
      DRAW: begin
        try_n = try_inc;
        if (accept) begin
          value_n = m;
          state_n = ACK;
        end else if (try_inc == TW'(MAX_TRY)) begin
          value_n = m >> 1;
          state_n = ACK;
        end
      end
      ACK: begin
        ptr_n   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      lim      <= '0;
      try_q    <= '0;
      value    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant_id <= gid_n;
      lim      <= lim_n;
      try_q    <= try_n;
      value    <= value_n;
    end
  end

  always_comb begin
    ack = '0;
    if (state == ACK) ack[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rnd_arbiter.sv
// Bench for rnd_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model.
module tb_rnd_arbiter;
  localparam int N  = 4;
  localparam int W  = 6;
  localparam int MT = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   rnd_in = '0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] limit = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   value;
  logic           busy;
  logic [1:0]     grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rnd_arbiter #(.N_REQ(N), .W(W), .MAX_TRY(MT)) dut (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .req(req), .limit(limit),
    .ack(ack), .value(value), .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Smallest power of two at or above lim, minus one.
  function automatic int mask_of(input int lim);
    int p;
    p = 1;
    while (p < lim) p = p * 2;
    return p - 1;
  endfunction

  // Model: who is being served, how many samples drawn, and the outputs expected next cycle.
  int         serving = -1;
  bit         acking = 0;
  int         m_ptr = 0, m_lim = 0, m_tries = 0;
  int         e_ack = 0, e_val = 0, e_busy = 0, e_gid = 0;
  logic [N-1:0] prev_ack = '0;

  always @(negedge clk) begin
    int s, f;
    bit done;
    if (!rst_n) begin
      serving = -1; acking = 0; m_ptr = 0;
      e_ack = 0; e_val = 0; e_busy = 0; e_gid = 0;
    end
    chk("cyc_ack", int'(ack), e_ack);
    chk("cyc_value", int'(value), e_val);
    chk("cyc_busy", int'(busy), e_busy);
    chk("cyc_grant_id", int'(grant_id), e_gid);
    prev_ack = ack;
    if (rst_n) begin
      if (acking) begin
        m_ptr = (serving + 1) % N;
        acking = 0; serving = -1; e_ack = 0; e_busy = 0;
      end else if (serving < 0) begin
        for (int off = 0; off < N; off++) begin
          f = (m_ptr + off) % N;
          if (serving < 0 && req[f]) begin
            serving = f;
            m_lim = int'(limit[f*W +: W]);
            if (m_lim == 0) m_lim = 1 << W;
            m_tries = 0; e_gid = f; e_busy = 1;
          end
        end
      end else begin
        m_tries++;
        s = int'(rnd_in) & mask_of(m_lim);
        done = 0;
        if (s < m_lim) begin e_val = s; done = 1; end
        else if (m_tries == MT) begin e_val = s / 2; done = 1; end
        if (done) begin acking = 1; e_ack = 1 << serving; end
      end
    end
  end

  // From an IDLE cycle: raise, one accepted draw, check the ack cycle, drop in the following cycle.
  task automatic serve(input logic [N-1:0] raise, input logic [W-1:0] rv, input int id, input int ev, input string nm);
    req = req | raise;
    tick();
    rnd_in = rv;
    tick();
    @(negedge clk);
    chk({nm, "_ack"}, int'(ack), 1 << id);
    chk({nm, "_val"}, int'(value), ev);
    @(posedge clk);
    #1;
    req[id] = 1'b0;
  endtask

  initial begin
    int prev, ex;
    logic [W-1:0] rv;

    chk("model_mask10", mask_of(10), 15);
    chk("model_mask5", mask_of(5), 7);
    chk("model_mask1", mask_of(1), 0);

    repeat (2) @(negedge clk);
    chk("rst_ack", int'(ack), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gid", int'(grant_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Reject 0x2B (m=11), accept 0x07.
    limit[0*W +: W] = 6'd10; req[0] = 1'b1;
    tick();
    rnd_in = 6'h2B;
    @(negedge clk); chk("acc_busy1", int'(busy), 1);
    @(posedge clk); #1; rnd_in = 6'h07;
    @(negedge clk); chk("acc_noack2", int'(ack), 0); chk("acc_busy2", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk); chk("acc_ack", int'(ack), 1); chk("acc_val", int'(value), 7); chk("acc_busy3", int'(busy), 1);
    @(posedge clk); #1; req[0] = 1'b0;
    @(negedge clk); chk("acc_idle", int'(busy), 0);

    // Fallback: lim 5, sample always 7.
    tick();
    limit[2*W +: W] = 6'd5; req[2] = 1'b1; rnd_in = 6'h3F;
    for (int t = 1; t <= 7; t++) begin
      tick();
      @(negedge clk); chk("fb_wait", int'(ack), 0);
    end
    tick();
    @(negedge clk); chk("fb_ack", int'(ack), 4); chk("fb_val", int'(value), 3);
    tick(); req[2] = 1'b0;

    limit[3*W +: W] = 6'd0;
    serve(4'b1000, 6'h2A, 3, 42, "full");
    limit[0*W +: W] = 6'd1;
    serve(4'b0001, 6'h3F, 0, 0, "one");

    // Reset in the middle of a draw that would otherwise fall back.
    limit[1*W +: W] = 6'd5; req[1] = 1'b1; rnd_in = 6'h3F;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ack", int'(ack), 0);
    req[1] = 1'b0;
    repeat (3) begin @(negedge clk); chk("mid_rst_noack", int'(ack), 0); end
    @(posedge clk); #1; rst_n = 1'b1;

    // Round robin from ptr 0 with all requesters busy.
    limit = '0; req = 4'b1111; prev = -1;
    for (int n = 0; n < 5; n++) begin
      ex = n % N;
      tick();
      if (prev >= 0) req[prev] = 1'b1;
      rv = W'($urandom); rnd_in = rv;
      tick();
      @(negedge clk);
      chk("rr_ack", int'(ack), 1 << ex);
      chk("rr_val", int'(value), int'(rv));
      @(posedge clk); #1;
      req[ex] = 1'b0;
      prev = ex;
    end
    req = '0;

    serve(4'b0010, 6'h01, 1, 1, "adv1");
    serve(4'b0100, 6'h02, 2, 2, "adv2");
    serve(4'b1001, 6'h11, 3, 17, "fair3");
    serve(4'b0000, 6'h22, 0, 34, "fair0");
    serve(4'b0011, 6'h05, 1, 5, "wrap1");
    req = '0;

    for (int c = 0; c < 3000; c++) begin
      rnd_in = ($urandom_range(3) == 0) ? 6'h3F : W'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req[i] && prev_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          case ($urandom_range(3))
            0: limit[i*W +: W] = 6'd0;
            1: limit[i*W +: W] = 6'd1;
            default: limit[i*W +: W] = W'($urandom);
          endcase
          req[i] = 1'b1;
        end
      end
      tick();
    end
    req = '0;
    repeat (MT + 6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
